// File: rtl/lcd_pkg.sv
// lcd_pkg: FSM and strobe-phase types, HD44780 command bytes and sizing helpers
// shared by text_lcd_driver and lcd_write_strobe.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_ADDR1,
    ST_CHAR1,
    ST_ADDR2,
    ST_CHAR2
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EHIGH,
    PH_SETTLE
  } strobe_phase_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Down-counters end on zero, so a wait of N cycles loads N-1; zero still costs one cycle.
  function automatic int unsigned wait_load(input int unsigned cyc);
    return (cyc == 0) ? 0 : cyc - 1;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// lcd_write_strobe: one HD44780 write -- setup cycle, E pulse, then settle wait with
// rs/data held. o_done marks idle or the last settle cycle; i_start is accepted then.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned E_HIGH_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic       i_long,
  input  logic [7:0] i_data,
  output logic       o_done,
  output logic       o_e_fall,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic [7:0] o_lcd_data
);

  localparam logic [CNT_W-1:0] E_LOAD   = CNT_W'(wait_load(E_HIGH_CYC));
  localparam logic [CNT_W-1:0] CMD_LOAD = CNT_W'(wait_load(CMD_WAIT_CYC));
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(wait_load(CLR_WAIT_CYC));

  strobe_phase_t    r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_e, r_rs, r_long;
  logic [7:0]       r_data;
  logic             w_cnt_zero, w_load;

  assign w_cnt_zero = (r_cnt == '0);
  assign o_done     = (r_phase == PH_IDLE) || ((r_phase == PH_SETTLE) && w_cnt_zero);
  assign o_e_fall   = (r_phase == PH_EHIGH) && w_cnt_zero;
  assign w_load     = i_start && o_done;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    case (r_phase)
      PH_SETUP: begin
        w_phase_nxt = PH_EHIGH;
        w_cnt_nxt   = E_LOAD;
      end
      PH_EHIGH: begin
        if (w_cnt_zero) begin
          w_phase_nxt = PH_SETTLE;
          w_cnt_nxt   = r_long ? CLR_LOAD : CMD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      PH_SETTLE: begin
        if (w_cnt_zero) w_phase_nxt = PH_IDLE;
        else            w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: ;
    endcase
    if (w_load) w_phase_nxt = PH_SETUP;
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_long  <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_e     <= (w_phase_nxt == PH_EHIGH);
      if (w_load) begin
        r_rs   <= i_rs;
        r_long <= i_long;
        r_data <= i_data;
      end
    end
  end

  assign o_lcd_e    = r_e;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_data = r_data;

endmodule

// File: rtl/text_lcd_driver.sv
// text_lcd_driver: power-up, init and continuous 16x2 refresh of an HD44780 from a slot source.
// Define LCD_FRAME_DONE_EN to add the frame_done pulse after slot 31.
module text_lcd_driver
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned INIT_WAIT_US = 20000,
  parameter int unsigned CMD_WAIT_US  = 50,
  parameter int unsigned CLR_WAIT_US  = 2000,
  parameter int unsigned E_HIGH_CYC   = 25
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] index,
  input  logic [7:0] char_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
`ifdef LCD_FRAME_DONE_EN
  ,
  output logic       frame_done
`endif
);

  localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1000000;
  localparam int unsigned INIT_CYC   = INIT_WAIT_US * CYC_PER_US;
  localparam int unsigned CMD_CYC    = CMD_WAIT_US * CYC_PER_US;
  localparam int unsigned CLR_CYC    = CLR_WAIT_US * CYC_PER_US;
  localparam int unsigned MAX_CYC    = umax(umax(INIT_CYC, CLR_CYC), umax(CMD_CYC, E_HIGH_CYC));
  localparam int unsigned CNT_W      = cnt_width(MAX_CYC);
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(wait_load(INIT_CYC));

  lcd_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_pwr_cnt, w_pwr_cnt_nxt;
  logic [1:0]       r_init_step, w_init_step_nxt;
  logic [4:0]       r_index, w_index_nxt;
  logic             w_start, w_rs, w_long, w_done, w_e_fall;
  logic [7:0]       w_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_PWRUP;
      r_pwr_cnt   <= '0;
      r_init_step <= 2'd0;
      r_index     <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pwr_cnt   <= w_pwr_cnt_nxt;
      r_init_step <= w_init_step_nxt;
      r_index     <= w_index_nxt;
    end
  end

  // Transitions fire on the E falling edge, so index moves at the start of the settle wait.
  always_comb begin
    w_state_nxt     = r_state;
    w_pwr_cnt_nxt   = r_pwr_cnt;
    w_init_step_nxt = r_init_step;
    w_index_nxt     = r_index;
    w_start         = (r_state != ST_PWRUP) && w_done;
    w_rs            = 1'b0;
    w_long          = 1'b0;
    w_data          = 8'h00;
    case (r_state)
      ST_PWRUP: begin
        if (r_pwr_cnt == PWR_LOAD) w_state_nxt   = ST_INIT;
        else                       w_pwr_cnt_nxt = r_pwr_cnt + 1'b1;
      end
      ST_INIT: begin
        w_data = init_cmd(r_init_step);
        w_long = (r_init_step == 2'd3);
        if (w_e_fall) begin
          if (r_init_step == 2'd3) begin
            w_state_nxt     = ST_ADDR1;
            w_init_step_nxt = 2'd0;
          end else begin
            w_init_step_nxt = r_init_step + 2'd1;
          end
        end
      end
      ST_ADDR1: begin
        w_data = CMD_LINE1;
        if (w_e_fall) begin
          w_state_nxt = ST_CHAR1;
          w_index_nxt = 5'd0;
        end
      end
      ST_CHAR1: begin
        w_rs   = 1'b1;
        w_data = char_data;
        if (w_e_fall) begin
          if (r_index == 5'd15) begin
            w_state_nxt = ST_ADDR2;
            w_index_nxt = 5'd0;
          end else begin
            w_index_nxt = r_index + 5'd1;
          end
        end
      end
      ST_ADDR2: begin
        w_data = CMD_LINE2;
        if (w_e_fall) begin
          w_state_nxt = ST_CHAR2;
          w_index_nxt = 5'd16;
        end
      end
      ST_CHAR2: begin
        w_rs   = 1'b1;
        w_data = char_data;
        if (w_e_fall) begin
          if (r_index == 5'd31) begin
            w_state_nxt = ST_ADDR1;
            w_index_nxt = 5'd0;
          end else begin
            w_index_nxt = r_index + 5'd1;
          end
        end
      end
      default: w_state_nxt = ST_PWRUP;
    endcase
  end

  lcd_write_strobe #(
    .E_HIGH_CYC  (E_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_CYC),
    .CLR_WAIT_CYC(CLR_CYC),
    .CNT_W       (CNT_W)
  ) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_rs      (w_rs),
    .i_long    (w_long),
    .i_data    (w_data),
    .o_done    (w_done),
    .o_e_fall  (w_e_fall),
    .o_lcd_e   (lcd_e),
    .o_lcd_rs  (lcd_rs),
    .o_lcd_data(lcd_data)
  );

  assign index  = r_index;
  assign lcd_rw = 1'b0;

`ifdef LCD_FRAME_DONE_EN
  logic r_frame_pend, r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_pend <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done && r_frame_pend;
      if (w_e_fall && (r_state == ST_CHAR2) && (r_index == 5'd31)) r_frame_pend <= 1'b1;
      else if (w_done)                                             r_frame_pend <= 1'b0;
    end
  end

  assign frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_text_lcd_driver.sv
// tb_text_lcd_driver: expected LCD writes are queued per phase and popped on each lcd_e strobe;
// build with LCD_FRAME_DONE_EN defined to also cover the frame_done pulse.
module tb_text_lcd_driver;

  localparam int CMD_SETTLE = 5;
  localparam int CLR_SETTLE = 10;
  localparam int INIT_QUIET = 20;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         settle;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] index;
  logic [7:0] char_data = 8'h41;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
`ifdef LCD_FRAME_DONE_EN
  logic       frame_done;
  int         fd_cnt = 0;
`endif

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  text_lcd_driver #(
    .CLK_FREQ_HZ (1000000),
    .INIT_WAIT_US(20),
    .CMD_WAIT_US (5),
    .CLR_WAIT_US (10),
    .E_HIGH_CYC  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .index    (index),
    .char_data(char_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
`ifdef LCD_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic rs, input logic [7:0] data);
    wr_t w;
    w.rs     = rs;
    w.data   = data;
    w.settle = (!rs && data == 8'h01) ? CLR_SETTLE : CMD_SETTLE;
    exp_q.push_back(w);
  endtask

  task automatic push_init();
    push_wr(1'b0, 8'h38);
    push_wr(1'b0, 8'h0C);
    push_wr(1'b0, 8'h06);
    push_wr(1'b0, 8'h01);
  endtask

  task automatic push_frame();
    push_wr(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_wr(1'b1, 8'h41 + 8'(i));
    push_wr(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) push_wr(1'b1, 8'h41 + 8'(i));
  endtask

  task automatic count_quiet(output int low_cnt, output logic seen);
    low_cnt = 0;
    seen    = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (lcd_e === 1'b1) seen = 1'b1;
      else                low_cnt++;
    end
  endtask

  task automatic wait_drained(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  // Registered display source: char_data follows index one clock later.
  initial begin : source
    logic [4:0] idx_s;
    forever begin
      @(posedge clk);
      idx_s = index;
      #1 char_data = 8'h41 + {3'b000, idx_s};
    end
  end

  initial begin : monitor
    wr_t  cur;
    logic prev_e, prev_fd, have_cur, in_settle;
    int   settle_cnt, writes_since_fd, exp_writes;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_e          = 1'b0;
        prev_fd         = 1'b0;
        have_cur        = 1'b0;
        in_settle       = 1'b0;
        settle_cnt      = 0;
        writes_since_fd = 0;
        exp_writes      = 38;
      end else begin
        if (lcd_e === 1'b1 && !prev_e) begin
          if (have_cur)
            check($sformatf("settle_after_%02h", cur.data), 32'(settle_cnt), 32'(cur.settle));
          check("write_queued", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            check($sformatf("wr_rs_%02h", cur.data), 32'(lcd_rs), 32'(cur.rs));
            check("wr_data", 32'(lcd_data), 32'(cur.data));
            check("wr_rw", 32'(lcd_rw), 0);
          end
          in_settle = 1'b0;
          writes_since_fd++;
        end else if (lcd_e === 1'b0 && prev_e) begin
          in_settle  = 1'b1;
          settle_cnt = 0;
        end
        if (lcd_e === 1'b0 && in_settle) begin
          if (lcd_data === cur.data && lcd_rs === cur.rs) settle_cnt++;
          else                                            in_settle = 1'b0;
        end
`ifdef LCD_FRAME_DONE_EN
        if (frame_done === 1'b1) begin
          check("fd_width", 32'(prev_fd), 0);
          check("fd_writes", 32'(writes_since_fd), 32'(exp_writes));
          check("fd_next_cmd", 32'(lcd_data), 32'h80);
          fd_cnt++;
          writes_since_fd = 0;
          exp_writes      = 34;
        end
        prev_fd = frame_done;
`endif
        prev_e = lcd_e;
      end
    end
  end

  initial begin : stimulus
    int   low_cnt;
    logic seen;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_lcd_e", 32'(lcd_e), 0);
    check("rst_lcd_rs", 32'(lcd_rs), 0);
    check("rst_lcd_rw", 32'(lcd_rw), 0);
    check("rst_lcd_data", 32'(lcd_data), 0);
    check("rst_index", 32'(index), 0);
`ifdef LCD_FRAME_DONE_EN
    check("rst_frame_done", 32'(frame_done), 0);
`endif

    push_init();
    repeat (3) push_frame();
    rst    = 1'b0;
    mon_en = 1'b1;
    count_quiet(low_cnt, seen);
    check("pwrup_quiet", 32'(low_cnt >= INIT_QUIET), 1);
    check("pwrup_first_strobe", 32'(seen), 1);
    wait_drained(3000);
    mon_en = 1'b0;
`ifdef LCD_FRAME_DONE_EN
    check("fd_count", 32'(fd_cnt), 2);
`endif

    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      seen = (lcd_e === 1'b1) && (index >= 5'd20);
    end
    check("char2_strobe_found", 32'(seen), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_lcd_e", 32'(lcd_e), 0);
    check("async_rst_index", 32'(index), 0);
    check("async_rst_data", 32'(lcd_data), 0);
    check("async_rst_rs", 32'(lcd_rs), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);

    push_init();
    push_frame();
    rst    = 1'b0;
    mon_en = 1'b1;
    count_quiet(low_cnt, seen);
    check("restart_quiet", 32'(low_cnt >= INIT_QUIET), 1);
    check("restart_first_strobe", 32'(seen), 1);
    wait_drained(1500);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
